ps2_rx_fifo: RTL and testbench

- Parametrised successor to the single-shot PS/2 keyboard receiver.
- Fully synchronous to the system clock: no logic clocked by the PS/2 clock.
- Adds odd-parity and stop-bit checking, a frame timeout, and E0/F0 prefix decoding into per-entry flags.
- Buffers decoded scancodes in a show-ahead FIFO so no keystroke is lost between reads; sits between the PS/2 pad IOBUFs and the game input logic.

---
 rtl/ps2_rx_fifo.sv | 237 +++++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
`timescale 1ns/1ps
// ps2_rx_fifo
//   PS/2 keyboard receiver fully synchronous to clk. Both pad lines are
//   synchronised and glitch-filtered; 11-bit frames are checked for odd
//   parity and stop bit, with a timeout on stalled frames. E0/F0 prefixes
//   are folded into per-entry ext/brk flags and decoded scancodes are
//   buffered in a show-ahead FIFO.
// Ports
//   clk, rst          system clock, async active-high reset
//   ps2_clk_i         PS/2 clock pad input (asynchronous)
//   ps2_data_i        PS/2 data pad input (asynchronous)
//   rd_en             pop request; ignored while empty
//   rd_data[9:0]      head entry {ext, brk, code}; 0 while empty
//   empty, full       FIFO status
//   count             entries held
//   frame_err         one-cycle pulse per rejected or timed-out frame
//   overflow          sticky: an entry was dropped because the FIFO was full
// Handshake: rd_en is a ready-style pop qualified by !empty; rd_data is valid
//   whenever empty=0 and advances the cycle after an accepted pop.
module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 19,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int DEPTH_LOG2     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ps2_clk_i,
  input  logic                  ps2_data_i,
  input  logic                  rd_en,
  output logic [9:0]            rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  frame_err,
  output logic                  overflow
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int FW    = $clog2(FILTER_LEN + 1);
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_e;

  state_e                state_q, state_d;
  logic [1:0]            clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic                  clk_filt_q, clk_filt_d, data_filt_q, data_filt_d;
  logic [FW-1:0]         clk_fcnt_q, clk_fcnt_d, data_fcnt_q, data_fcnt_d;
  logic                  clk_prev_q, clk_prev_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [7:0]            shreg_q, shreg_d;
  logic                  parity_q, parity_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  logic                  ext_q, ext_d, brk_q, brk_d;
  logic                  dec_valid_q, dec_valid_d;
  logic [7:0]            dec_byte_q, dec_byte_d;
  logic                  frame_err_q, frame_err_d;
  logic [9:0]            mem_q [DEPTH], mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;

  logic fall, timeout, start, shift_en, par_en, stop_chk, frame_good, frame_bad;
  logic is_e0, is_f0, push, pop, full_w, empty_w, wr_ok;

  // Falling edge of the filtered clock: high last cycle, low now.
  assign fall    = clk_prev_q & ~clk_filt_q;
  // A falling edge restarts the timer, so it wins over an expiring count.
  assign timeout = (state_q != ST_IDLE) && !fall && (to_cnt_q == TW'(TIMEOUT_CYCLES));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = ST_IDLE;
    end else if (fall) begin
      case (state_q)
        ST_IDLE:   if (!data_filt_q) state_d = ST_DATA;
        ST_DATA:   if (bit_idx_q == 3'd7) state_d = ST_PARITY;
        ST_PARITY: state_d = ST_STOP;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    start      = fall && (state_q == ST_IDLE) && !data_filt_q;
    shift_en   = fall && (state_q == ST_DATA);
    par_en     = fall && (state_q == ST_PARITY);
    stop_chk   = fall && (state_q == ST_STOP);
    // Odd parity: the nine data+parity bits must hold an odd number of ones.
    frame_good = stop_chk && data_filt_q && (^{shreg_q, parity_q});
    frame_bad  = (stop_chk && !frame_good) || timeout;
  end

  // ---------------- Input conditioning ----------------
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk_i};
    data_sync_d = {data_sync_q[0], ps2_data_i};
    clk_prev_d  = clk_filt_q;

    // Filter: any agreeing sample restarts the count.
    clk_filt_d = clk_filt_q;
    clk_fcnt_d = '0;
    if (clk_sync_q[1] != clk_filt_q) begin
      if (clk_fcnt_q == FW'(FILTER_LEN - 1)) clk_filt_d = clk_sync_q[1];
      else                                   clk_fcnt_d = clk_fcnt_q + FW'(1);
    end

    data_filt_d = data_filt_q;
    data_fcnt_d = '0;
    if (data_sync_q[1] != data_filt_q) begin
      if (data_fcnt_q == FW'(FILTER_LEN - 1)) data_filt_d = data_sync_q[1];
      else                                    data_fcnt_d = data_fcnt_q + FW'(1);
    end
  end

  // ---------------- Frame datapath and decode ----------------
  always_comb begin
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    parity_d  = parity_q;
    if (start || timeout) begin
      bit_idx_d = '0;
      shreg_d   = '0;
    end else if (shift_en) begin
      bit_idx_d = bit_idx_q + 3'd1;
      shreg_d   = {data_filt_q, shreg_q[7:1]};  // LSB arrives first
    end
    if (par_en) parity_d = data_filt_q;

    if ((state_q == ST_IDLE) || fall || timeout) to_cnt_d = '0;
    else                                         to_cnt_d = to_cnt_q + TW'(1);

    frame_err_d = frame_bad;
    dec_valid_d = frame_good;
    dec_byte_d  = frame_good ? shreg_q : dec_byte_q;

    is_e0 = dec_valid_q && (dec_byte_q == 8'hE0);
    is_f0 = dec_valid_q && (dec_byte_q == 8'hF0);
    push  = dec_valid_q && !is_e0 && !is_f0;

    // Prefix flags accumulate until a non-prefix byte consumes them.
    ext_d = ext_q;
    brk_d = brk_q;
    if (frame_bad) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (is_e0) begin
      ext_d = 1'b1;
    end else if (is_f0) begin
      brk_d = 1'b1;
    end else if (push) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  // ---------------- FIFO ----------------
  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));
  assign pop     = rd_en && !empty_w;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_ok   = push && (!full_w || pop);

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[wr_ptr_q] = {ext_q, brk_q, dec_byte_q};
    wr_ptr_d   = wr_ok ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
    count_d    = count_q;
    if (wr_ok && !pop)      count_d = count_q + CW'(1);
    else if (!wr_ok && pop) count_d = count_q - CW'(1);
    overflow_d = overflow_q || (push && !wr_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_filt_q  <= 1'b1;
      data_filt_q <= 1'b1;
      clk_fcnt_q  <= '0;
      data_fcnt_q <= '0;
      clk_prev_q  <= 1'b1;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      parity_q    <= 1'b0;
      to_cnt_q    <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      dec_valid_q <= 1'b0;
      dec_byte_q  <= '0;
      frame_err_q <= 1'b0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_filt_q  <= clk_filt_d;
      data_filt_q <= data_filt_d;
      clk_fcnt_q  <= clk_fcnt_d;
      data_fcnt_q <= data_fcnt_d;
      clk_prev_q  <= clk_prev_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      parity_q    <= parity_d;
      to_cnt_q    <= to_cnt_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      dec_valid_q <= dec_valid_d;
      dec_byte_q  <= dec_byte_d;
      frame_err_q <= frame_err_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  assign rd_data   = empty_w ? 10'h000 : mem_q[rd_ptr_q];
  assign empty     = empty_w;
  assign full      = full_w;
  assign count     = count_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
`timescale 1ns/1ps
// Bench for ps2_rx_fifo: directed table, hand-written corner sequences and
// random frames checked against a queue-based model of the keyboard stream.
module tb_ps2_rx_fifo;
  localparam int FL    = 4;
  localparam int TO    = 400;
  localparam int DL    = 3;
  localparam int DEPTH = 1 << DL;
  localparam int HALF  = 20;   // clk cycles per PS/2 clock phase
  localparam int M_NORM = 0, M_LAT = 1, M_POP = 2;

  logic        clk, rst, ps2_clk_i, ps2_data_i, rd_en;
  logic [9:0]  rd_data;
  logic        empty, full, frame_err, overflow;
  logic [DL:0] count;

  ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
    .count(count), .frame_err(frame_err), .overflow(overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int err_seen = 0;

  always @(negedge clk) if (frame_err) err_seen++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  logic [9:0] exp_q[$];
  bit m_ext = 0, m_brk = 0, m_ovf = 0;
  int exp_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      exp_err++;
      m_ext = 0;
      m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, b});
      else m_ovf = 1;
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic check_state(input string tag);
    logic [9:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : 10'h000;
    check({tag, " count"},    32'(count),    32'(exp_q.size()));
    check({tag, " empty"},    32'(empty),    32'(exp_q.size() == 0));
    check({tag, " full"},     32'(full),     32'(exp_q.size() == DEPTH));
    check({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, " rd_data"},  32'(rd_data),  32'(head));
    check({tag, " frame_err count"}, 32'(err_seen), 32'(exp_err));
  endtask

  // ---------------- drivers ----------------
  task automatic read_one(input string tag);
    logic [9:0] head;
    @(negedge clk);
    head = (exp_q.size() > 0) ? exp_q[0] : 10'h000;
    check({tag, " read data"}, 32'(rd_data), 32'(head));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  // Sends the first nedges bits of a frame (11 = complete frame).
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit glitch, input int mode, input int nedges);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < nedges; i++) begin
      ps2_data_i = bits[i];
      if (glitch) begin
        repeat (HALF / 2) @(negedge clk);
        ps2_clk_i = 1'b0;
        repeat (FL - 1) @(negedge clk);
        ps2_clk_i = 1'b1;
        repeat (HALF - HALF / 2 - (FL - 1)) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk_i = 1'b0;
      if (i == 10 && mode == M_LAT) begin
        // filtered edge lands FL+2 cycles after the pad edge; entry 2 later
        repeat (FL + 3) @(negedge clk);
        check("latency empty before push", 32'(empty), 32'd1);
        @(negedge clk);
        check("latency empty after push", 32'(empty), 32'd0);
        repeat (HALF - FL - 4) @(negedge clk);
      end else if (i == 10 && mode == M_POP) begin
        repeat (FL + 3) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        repeat (HALF - FL - 4) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk_i = 1'b1;
    end
    ps2_data_i = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    bit         bad_stop;
    bit         exp_push;
    logic [9:0] exp_entry;
    bit         exp_err;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{8'h1C, 0, 0, 1, 10'h01C, 0};
    vecs[1]  = '{8'hE0, 0, 0, 0, 10'h000, 0};
    vecs[2]  = '{8'hF0, 0, 0, 0, 10'h000, 0};
    vecs[3]  = '{8'h74, 0, 0, 1, 10'h374, 0};
    vecs[4]  = '{8'h1C, 0, 0, 1, 10'h01C, 0};
    vecs[5]  = '{8'hF0, 0, 0, 0, 10'h000, 0};
    vecs[6]  = '{8'h1C, 1, 0, 0, 10'h000, 1};
    vecs[7]  = '{8'h1C, 0, 0, 1, 10'h01C, 0};
    vecs[8]  = '{8'hE0, 0, 0, 0, 10'h000, 0};
    vecs[9]  = '{8'h5A, 0, 1, 0, 10'h000, 1};
    vecs[10] = '{8'h5A, 0, 0, 1, 10'h05A, 0};
    vecs[11] = '{8'hF0, 0, 0, 0, 10'h000, 0};
    vecs[12] = '{8'hE0, 0, 0, 0, 10'h000, 0};
    vecs[13] = '{8'hF0, 0, 0, 0, 10'h000, 0};
    vecs[14] = '{8'h12, 0, 0, 1, 10'h312, 0};

    rst = 1'b1; ps2_clk_i = 1'b1; ps2_data_i = 1'b1; rd_en = 1'b0;
    repeat (3) @(negedge clk);
    check_state("reset");
    rst = 1'b0;
    repeat (FL + 5) @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop, 1'b0, M_NORM, 11);
      exp_err += int'(vecs[i].exp_err);
      check($sformatf("vec%0d frame_err count", i), 32'(err_seen), 32'(exp_err));
      check($sformatf("vec%0d empty", i), 32'(empty), 32'(!vecs[i].exp_push));
      if (vecs[i].exp_push) begin
        check($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(vecs[i].exp_entry));
        check($sformatf("vec%0d count", i), 32'(count), 32'd1);
        @(negedge clk); rd_en = 1'b1;
        @(negedge clk); rd_en = 1'b0;
        check($sformatf("vec%0d empty after pop", i), 32'(empty), 32'd1);
        check($sformatf("vec%0d rd_data after pop", i), 32'(rd_data), 32'd0);
      end
    end

    // latency of the first entry, then a read while empty
    send_frame(8'h1C, 0, 0, 0, M_LAT, 11);
    model_frame(8'h1C, 1);
    check_state("latency");
    read_one("latency");
    read_one("empty read");
    check_state("after empty read");

    // clock glitches shorter than the filter, one per high phase
    send_frame(8'h5A, 0, 0, 1, M_NORM, 11);
    model_frame(8'h5A, 1);
    check_state("glitch");
    read_one("glitch");

    // stalled frame: start + 4 data bits, then lines idle high
    send_frame(8'h00, 0, 0, 0, M_NORM, 5);
    repeat (TO - 2 * HALF - 10) @(negedge clk);
    check("timeout not early", 32'(err_seen), 32'(exp_err));
    repeat (FL + 34) @(negedge clk);
    exp_err++;
    check("timeout pulse", 32'(err_seen), 32'(exp_err));
    send_frame(8'h29, 0, 0, 0, M_NORM, 11);
    model_frame(8'h29, 1);
    check_state("after timeout");
    read_one("after timeout");

    // overflow: nine codes, no reads
    for (int c = 1; c <= 9; c++) begin
      send_frame(8'(c), 0, 0, 0, M_NORM, 11);
      model_frame(8'(c), 1);
    end
    check_state("overflow");
    for (int k = 0; k < DEPTH; k++) read_one("overflow drain");
    check_state("overflow drained");

    // reset asserted in the middle of a frame
    send_frame(8'h33, 0, 0, 0, M_NORM, 11);
    model_frame(8'h33, 1);
    check_state("pre reset");
    send_frame(8'h45, 0, 0, 0, M_NORM, 6);
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.delete(); m_ext = 0; m_brk = 0; m_ovf = 0;
    check("mid reset rd_data",   32'(rd_data),   32'd0);
    check("mid reset empty",     32'(empty),     32'd1);
    check("mid reset full",      32'(full),      32'd0);
    check("mid reset count",     32'(count),     32'd0);
    check("mid reset frame_err", 32'(frame_err), 32'd0);
    check("mid reset overflow",  32'(overflow),  32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (FL + 10) @(negedge clk);
    send_frame(8'h16, 0, 0, 0, M_NORM, 11);
    model_frame(8'h16, 1);
    check_state("after reset");
    read_one("after reset");

    // push and pop together while full: no loss, no overflow
    for (int c = 8'h10; c <= 8'h17; c++) begin
      send_frame(8'(c), 0, 0, 0, M_NORM, 11);
      model_frame(8'(c), 1);
    end
    check_state("full");
    send_frame(8'h18, 0, 0, 0, M_POP, 11);
    void'(exp_q.pop_front());
    model_frame(8'h18, 1);
    check_state("full push+pop");
    send_frame(8'h19, 0, 0, 0, M_NORM, 11);
    model_frame(8'h19, 1);
    check_state("full push drop");
    for (int k = 0; k < DEPTH; k++) read_one("full drain");
    check_state("full drained");

    // random frames and reads against the model
    for (int n = 0; n < 40; n++) begin
      logic [7:0] code;
      bit bp, bs, gl;
      int sel, nrd;
      sel = $urandom_range(0, 9);
      if (sel == 0)      code = 8'hE0;
      else if (sel == 1) code = 8'hF0;
      else               code = 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 9) == 0);
      bs = ($urandom_range(0, 14) == 0);
      gl = 1'($urandom_range(0, 1));
      send_frame(code, bp, bs, gl, M_NORM, 11);
      model_frame(code, !bp && !bs);
      check_state($sformatf("rand%0d", n));
      nrd = $urandom_range(0, 2);
      for (int r = 0; r < nrd; r++) read_one($sformatf("rand%0d", n));
      check_state($sformatf("rand%0d post read", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
